// File: rtl/divider_pkg.sv
// Shared types for the restoring divider: the control FSM state encoding.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_datapath.sv
// Restoring-division register/subtractor path: R, Q and the stored divisor.
// With DIVIDER_DIV_BY_ZERO_EN defined, a zero divisor loads the final result at init.
module divider_datapath #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         do_init,
    input  logic         do_shift,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] q,
    output logic [N:0]   r
);

    logic [N-1:0] d;
    logic [N+1:0] wide;
    logic [N+1:0] trial;
    logic         neg;

    // R stays below D, so the shifted value fits N+1 bits and the extra top bit is the borrow.
    assign wide  = {r, q[N-1]};
    assign trial = wide - {2'b00, d};
    assign neg   = trial[N+1];

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r <= '0;
            q <= '0;
            d <= '0;
        end else if (do_init) begin
            r <= '0;
            q <= dividend;
            d <= divisor;
`ifdef DIVIDER_DIV_BY_ZERO_EN
            if (divisor == '0) begin
                q <= '1;
                r <= {1'b0, dividend};
            end
`endif
        end else if (do_shift) begin
            r <= neg ? wide[N:0] : trial[N:0];
            q <= {q[N-2:0], ~neg};
        end
    end

endmodule

// File: rtl/divider.sv
// N-bit unsigned restoring divider: IDLE/RUN/DONE control around divider_datapath.
// Optional DIVIDER_DIV_BY_ZERO_EN adds div_by_zero and a RUN-skipping fast path.
module divider
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
`ifdef DIVIDER_DIV_BY_ZERO_EN
    ,
    output logic         div_by_zero
`endif
);

    localparam int CW = $clog2(N + 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic          do_init, do_shift;
    logic [N:0]    r;

    divider_datapath #(.N(N)) u_dp (
        .clock    (clock),
        .n_reset  (n_reset),
        .do_init  (do_init),
        .do_shift (do_shift),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (quotient),
        .r        (r)
    );

    assign remainder = r[N-1:0];
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt      = state;
        do_init  = 1'b0;
        do_shift = 1'b0;
        case (state)
            IDLE: if (start) begin
                do_init = 1'b1;
                nxt     = RUN;
`ifdef DIVIDER_DIV_BY_ZERO_EN
                if (divisor == '0) nxt = DONE;
`endif
            end
            RUN: begin
                do_shift = 1'b1;
                if (cnt == CW'(N - 1)) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Counts completed steps; ends at N, which fits CW bits without wrapping.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset)      cnt <= '0;
        else if (do_init)  cnt <= '0;
        else if (do_shift) cnt <= cnt + 1'b1;
    end

`ifdef DIVIDER_DIV_BY_ZERO_EN
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset)     div_by_zero <= 1'b0;
        else if (do_init) div_by_zero <= (divisor == '0);
    end
`endif

endmodule
